// File: rtl/iob_clint_pkg.sv
// ----------------------------------------------------------------------------
// iob_clint_pkg
// Shared constants and helpers for the core-local interruptor (CLINT).
//   - Register map bases (byte addresses) for msip, mtimecmp and mtime.
//   - Widths and reset value of the 64-bit timer registers.
//   - FSM state encodings for the bus handshake.
//   - apply_wstrb(): byte-strobed merge of a 32-bit write into a 32-bit word.
// Used by iob_clint (top) and iob_clint_cmp (per-hart compare).
// ----------------------------------------------------------------------------
package iob_clint_pkg;

    localparam logic [15:0] MSIP_BASE     = 16'h0000;
    localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
    localparam logic [15:0] MTIME_BASE    = 16'hBFF8;

    localparam int          MTIME_W       = 64;
    localparam logic [63:0] MTIMECMP_RST  = 64'hFFFF_FFFF_FFFF_FFFF;

    // Handshake FSM encodings
    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_RESP = 1'b1;

    // Replace each byte of old_w whose strobe is set with the matching byte of new_w.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                res[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_clint_cmp.sv
// ----------------------------------------------------------------------------
// iob_clint_cmp
// One hart's mtimecmp register plus its registered timer-interrupt compare.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   we_lo, we_hi  write enable for the low / high 32-bit half (already decoded)
//   wstrb, wdata  byte strobes and write data from the bus
//   mtime         current mtime register value
//   mtimecmp_o    current mtimecmp value (for read-back)
//   irq_o         registered (mtime >= mtimecmp), unsigned 64-bit
// ----------------------------------------------------------------------------
module iob_clint_cmp
    import iob_clint_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we_lo,
    input  logic        we_hi,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    input  logic [63:0] mtime,
    output logic [63:0] mtimecmp_o,
    output logic        irq_o
);

    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        irq_q, irq_d;

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        if (we_lo) begin
            mtimecmp_d[31:0] = apply_wstrb(mtimecmp_q[31:0], wdata, wstrb);
        end
        if (we_hi) begin
            mtimecmp_d[63:32] = apply_wstrb(mtimecmp_q[63:32], wdata, wstrb);
        end
        // Compare the current registers, so the interrupt trails any change by one cycle.
        irq_d = (mtime >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mtimecmp_q <= MTIMECMP_RST;
            irq_q      <= 1'b0;
        end else begin
            mtimecmp_q <= mtimecmp_d;
            irq_q      <= irq_d;
        end
    end

    assign mtimecmp_o = mtimecmp_q;
    assign irq_o      = irq_q;

endmodule

// File: rtl/iob_clint.sv
// ----------------------------------------------------------------------------
// iob_clint
// RISC-V core-local interruptor on an IOb native slave port.
// Register map (byte addresses, bits [1:0] ignored):
//   0x0000+4i            msip[i] (bit 0)
//   0x4000+8i / +4       mtimecmp[i] low / high
//   0xBFF8 / 0xBFFC      mtime low / high
//   anything else, or hart >= N_CORES: read 0, write ignored, ready still pulses
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   valid, address,     request (valid held until ready), byte address,
//   wdata, wstrb        write data, byte strobes (all zero = read)
//   rdata, ready        response data (0 unless ready), one-cycle completion
//   mtime_o             current mtime (debug/trace)
//   timerInterrupt      per hart: registered mtime >= mtimecmp[i]
//   softwareInterrupt   per hart: registered msip[i]
//   state_o             handshake FSM state (0 = IDLE, 1 = RESP)
// Optional build macro: CLINT_PRESCALER_EN adds parameter PRESCALE and
// advances mtime once every PRESCALE cycles instead of every cycle.
//
// Handshake: a request is accepted in IDLE when valid=1; any write commits on
// that clock edge and the FSM moves to RESP, where ready=1 for exactly one
// cycle with rdata registered from the accept cycle. RESP never accepts, so
// the next request can be taken at the earliest in the cycle after RESP.
// ----------------------------------------------------------------------------
module iob_clint
    import iob_clint_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int N_CORES = 1
`ifdef CLINT_PRESCALER_EN
    ,
    parameter int PRESCALE = 100
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic [63:0]         mtime_o,
    output logic [N_CORES-1:0]  timerInterrupt,
    output logic [N_CORES-1:0]  softwareInterrupt,
    output logic                state_o
);

    localparam logic [12:0] MTIME_WORD = MTIME_BASE[15:3];

    logic                state_q, state_d;
    logic                ready_q, ready_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [63:0]         mtime_q, mtime_d;
    logic [N_CORES-1:0]  msip_q, msip_d;
    logic [N_CORES-1:0]  sw_irq_q, sw_irq_d;

    logic                tick;
    logic                accept;
    logic                wr_en;

    logic [31:0]         addr_ext;
    logic [15:0]         addr16;
    logic                addr_hi_ok;
    logic                msip_sel;
    logic [11:0]         msip_hart;
    logic                cmp_sel;
    logic [15:0]         cmp_off;
    logic [12:0]         cmp_hart;
    logic                mtime_sel;
    logic [DATA_W-1:0]   rd_val;

    logic [63:0]         cmp_val [N_CORES];
    logic [N_CORES-1:0]  cmp_we_lo;
    logic [N_CORES-1:0]  cmp_we_hi;
    logic [N_CORES-1:0]  timer_irq;

    logic                unused_bits;

    // ------------------------------------------------------------------
    // Tick enable
    // ------------------------------------------------------------------
`ifdef CLINT_PRESCALER_EN
    localparam logic [15:0] PRESCALE_RELOAD = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;

    // Free-running: mtime writes do not touch the prescaler phase.
    always_comb begin
        tick    = (presc_q == 16'd0);
        presc_d = tick ? PRESCALE_RELOAD : (presc_q - 16'd1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= PRESCALE_RELOAD;
        end else begin
            presc_q <= presc_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    always_comb begin
        addr_ext   = 32'(address);
        addr16     = addr_ext[15:0];
        addr_hi_ok = (addr_ext[31:16] == 16'd0);

        msip_sel   = addr_hi_ok && (addr16 < MTIMECMP_BASE);
        msip_hart  = addr16[13:2];

        cmp_sel    = addr_hi_ok && (addr16 >= MTIMECMP_BASE) && (addr16 < MTIME_BASE);
        cmp_off    = addr16 - MTIMECMP_BASE;
        cmp_hart   = cmp_off[15:3];

        mtime_sel  = addr_hi_ok && (addr16[15:3] == MTIME_WORD);
    end

    assign unused_bits = ^{addr_ext[1:0], cmp_off[1:0]};

    assign accept = (state_q == STATE_IDLE) && valid;
    assign wr_en  = accept && (|wstrb);

    // ------------------------------------------------------------------
    // Read mux (value captured into rdata_q at acceptance)
    // ------------------------------------------------------------------
    always_comb begin
        rd_val = '0;
        if (msip_sel) begin
            for (int i = 0; i < N_CORES; i++) begin
                if (int'(msip_hart) == i) begin
                    rd_val = {{(DATA_W-1){1'b0}}, msip_q[i]};
                end
            end
        end
        if (cmp_sel) begin
            for (int i = 0; i < N_CORES; i++) begin
                if (int'(cmp_hart) == i) begin
                    rd_val = cmp_off[2] ? cmp_val[i][63:32] : cmp_val[i][31:0];
                end
            end
        end
        if (mtime_sel) begin
            rd_val = addr16[2] ? mtime_q[63:32] : mtime_q[31:0];
        end
    end

    // ------------------------------------------------------------------
    // Register writes: msip, mtimecmp enables, mtime
    // ------------------------------------------------------------------
    always_comb begin
        msip_d    = msip_q;
        cmp_we_lo = '0;
        cmp_we_hi = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (wr_en && msip_sel && (int'(msip_hart) == i) && wstrb[0]) begin
                msip_d[i] = wdata[0];
            end
            if (wr_en && cmp_sel && (int'(cmp_hart) == i)) begin
                cmp_we_lo[i] = ~cmp_off[2];
                cmp_we_hi[i] = cmp_off[2];
            end
        end
        sw_irq_d = msip_q;

        // A bus write to mtime takes priority over the tick increment.
        mtime_d = mtime_q;
        if (wr_en && mtime_sel) begin
            if (addr16[2]) begin
                mtime_d[63:32] = apply_wstrb(mtime_q[63:32], wdata, wstrb);
            end else begin
                mtime_d[31:0] = apply_wstrb(mtime_q[31:0], wdata, wstrb);
            end
        end else if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
    end

    // ------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        rdata_d = '0;
        case (state_q)
            STATE_IDLE: begin
                if (valid) begin
                    state_d = STATE_RESP;
                    ready_d = 1'b1;
                    rdata_d = rd_val;
                end
            end
            STATE_RESP: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= STATE_IDLE;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            mtime_q  <= '0;
            msip_q   <= '0;
            sw_irq_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            mtime_q  <= mtime_d;
            msip_q   <= msip_d;
            sw_irq_q <= sw_irq_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-hart compare units
    // ------------------------------------------------------------------
    for (genvar g = 0; g < N_CORES; g++) begin : g_cmp
        iob_clint_cmp u_cmp (
            .clk        (clk),
            .rst        (rst),
            .we_lo      (cmp_we_lo[g]),
            .we_hi      (cmp_we_hi[g]),
            .wstrb      (wstrb[3:0]),
            .wdata      (wdata[31:0]),
            .mtime      (mtime_q),
            .mtimecmp_o (cmp_val[g]),
            .irq_o      (timer_irq[g])
        );
    end

    assign rdata             = rdata_q;
    assign ready             = ready_q;
    assign mtime_o           = mtime_q;
    assign timerInterrupt    = timer_irq;
    assign softwareInterrupt = sw_irq_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_iob_clint.sv
// ----------------------------------------------------------------------------
// tb_iob_clint
// Directed bench for iob_clint (default build, N_CORES=1, mtime ticks every
// cycle). Inputs change 1 ns after a rising edge; outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_iob_clint;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic [63:0] mtime_o;
    logic [0:0]  timer_irq;
    logic [0:0]  sw_irq;
    logic        state_o;

    int checks   = 0;
    int failures = 0;

    iob_clint #(
        .ADDR_W  (16),
        .DATA_W  (32),
        .N_CORES (1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .valid             (valid),
        .address           (address),
        .wdata             (wdata),
        .wstrb             (wstrb),
        .rdata             (rdata),
        .ready             (ready),
        .mtime_o           (mtime_o),
        .timerInterrupt    (timer_irq),
        .softwareInterrupt (sw_irq),
        .state_o           (state_o)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Check helper
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: req presents a request and returns 1 ns after the accept edge.
    task automatic req(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        address = a;
        wdata   = d;
        wstrb   = s;
        valid   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic fin();
        valid = 1'b0;
        wstrb = '0;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [31:0] exp);
        logic [31:0] r;
        req(a, 32'd0, 4'b0000);
        chk({tag, "_ready"}, ready, 1'b1);
        r = rdata;
        fin();
        chk({tag, "_data"}, r, exp);
        chk({tag, "_idle_rdata"}, rdata, 32'd0);
    endtask

    task automatic wr(input string tag, input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        req(a, d, s);
        chk({tag, "_ready"}, ready, 1'b1);
        fin();
    endtask

    initial begin
        int n;
        int pulses;

        // ---------------- reset state ----------------
        #12;
        chk("rst_ready", ready, 1'b0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mtime", mtime_o, 64'd0);
        chk("rst_timer", timer_irq, 1'b0);
        chk("rst_sw", sw_irq, 1'b0);
        chk("rst_state", state_o, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // ---------------- free-running mtime ----------------
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        chk("mtime_10", mtime_o, 64'd10);
        req(16'hBFF8, 32'd0, 4'b0000);
        chk("mtime_rd_ready", ready, 1'b1);
        chk("mtime_rd_state", state_o, 1'b1);
        chk("mtime_rd_lo_preinc", rdata, 32'd10);
        chk("mtime_after_accept", mtime_o, 64'd11);
        fin();
        chk("mtime_rd_drop", ready, 1'b0);
        rd("mtime_hi", 16'hBFFC, 32'd0);
        chk("idle_timer", timer_irq, 1'b0);
        chk("idle_sw", sw_irq, 1'b0);

        // ---------------- timer compare ----------------
        wr("cmp_hi0", 16'h4004, 32'd0, 4'hF);
        wr("cmp_lo40", 16'h4000, 32'd40, 4'hF);
        chk("cmp_pending", timer_irq, 1'b0);
        n = 0;
        while (mtime_o != 64'd40 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("mtime_reach_40", mtime_o, 64'd40);
        chk("timer_at_40", timer_irq, 1'b0);
        @(posedge clk);
        #1;
        chk("timer_rise", timer_irq, 1'b1);
        req(16'h4004, 32'd1, 4'hF);
        chk("cmp_hi1_ready", ready, 1'b1);
        chk("timer_commit_cycle", timer_irq, 1'b1);
        fin();
        chk("timer_clear", timer_irq, 1'b0);
        rd("cmp_lo_rb", 16'h4000, 32'd40);
        rd("cmp_hi_rb", 16'h4004, 32'd1);
        // 0x28 with bytes 0 and 2 replaced from 0xAABBCCDD
        wr("cmp_strb", 16'h4000, 32'hAABB_CCDD, 4'b0101);
        rd("cmp_strb_rb", 16'h4000, 32'h00BB_00DD);

        // ---------------- mtime write and wrap ----------------
        wr("mtime_hi_w", 16'hBFFC, 32'hFFFF_FFFF, 4'hF);
        req(16'hBFF8, 32'hFFFF_FFFE, 4'hF);
        chk("mtime_lo_w_ready", ready, 1'b1);
        chk("mtime_write_no_inc", mtime_o, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("timer_big_mtime", timer_irq, 1'b1);
        fin();
        chk("mtime_tick1", mtime_o, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk);
        #1;
        chk("mtime_wrap", mtime_o, 64'd0);
        @(posedge clk);
        #1;
        chk("timer_after_wrap", timer_irq, 1'b0);

        // ---------------- msip ----------------
        req(16'h0000, 32'd1, 4'b0001);
        chk("msip_w_ready", ready, 1'b1);
        chk("sw_commit_cycle", sw_irq, 1'b0);
        fin();
        chk("sw_set", sw_irq, 1'b1);
        wr("msip_strb1", 16'h0000, 32'd0, 4'b0010);
        chk("sw_unchanged", sw_irq, 1'b1);
        rd("msip_rb", 16'h0000, 32'd1);

        // ---------------- unmapped / out-of-range harts ----------------
        rd("unmapped_2000", 16'h2000, 32'd0);
        rd("msip_hart1", 16'h0004, 32'd0);
        rd("cmp_hart1", 16'h4008, 32'd0);
        wr("unmapped_w", 16'h2000, 32'hFFFF_FFFF, 4'hF);
        rd("msip_after_unmapped", 16'h0000, 32'd1);

        // ---------------- valid held for 4 cycles ----------------
        address = 16'h0000;
        wstrb   = 4'b0000;
        valid   = 1'b1;
        pulses  = 0;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk);
            #1;
            chk("hold_ready", ready, logic'(c % 2));
            chk("hold_rdata", rdata, (c % 2 == 1) ? 32'd1 : 32'd0);
            if (ready) pulses++;
        end
        valid = 1'b0;
        chk("hold_pulses", pulses, 2);

        // ---------------- reset during RESP ----------------
        req(16'h4000, 32'h1234_5678, 4'hF);
        chk("rstresp_ready", ready, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstresp_ready_low", ready, 1'b0);
        chk("rstresp_rdata", rdata, 32'd0);
        chk("rstresp_state", state_o, 1'b0);
        valid = 1'b0;
        wstrb = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        rd("rstresp_mtime", 16'hBFF8, 32'd0);
        rd("rstresp_cmp_lo", 16'h4000, 32'hFFFF_FFFF);
        rd("rstresp_cmp_hi", 16'h4004, 32'hFFFF_FFFF);
        chk("rstresp_timer", timer_irq, 1'b0);
        chk("rstresp_sw", sw_irq, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
